// File: rtl/pr_bus_arbiter_if.sv
// Per-master transfer channel between one bus master and the arbiter.
// Request fields flow master->arbiter; grant and read return flow back.
interface pr_bus_arbiter_if;
  logic        req;
  logic        lock;
  logic [29:0] addr;
  logic [31:0] wd;
  logic [3:0]  be;
  logic        we;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, lock, addr, wd, be, we,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, addr, wd, be, we,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/pr_bus_arbiter.sv
// Two-master round-robin arbiter in front of the peripheral bridge, with
// bounded hold, lock for atomic RMW and per-master read-data return.
module pr_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pr_bus_arbiter_if.slave       m0,
  pr_bus_arbiter_if.slave       m1,
  output logic [29:0]           PrAddrWire,
  output logic [31:0]           PrWDWire,
  output logic [3:0]            PrBEWire,
  output logic                  WeCPUWire,
  output logic                  RdCPUWire,
  input  logic [31:0]           PrRD
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rr_last_q, rr_last_d;
  logic              s1_vld_q, s1_vld_d;
  logic              s1_id_q, s1_id_d;
  logic [1:0]        rvalid_q;
  logic [31:0]       rdata0_q, rdata1_q;

  logic       owned_c, own_c;
  logic       own_req_c, oth_req_c, own_lock_c, own_we_c;
  logic       issue_c;
  logic [1:0] gnt_c;
  state_e     other_c;

  // Owner-relative views of the two request channels.
  assign owned_c    = (state_q != IDLE);
  assign own_c      = (state_q == OWN1);
  assign own_req_c  = own_c ? m1.req  : m0.req;
  assign oth_req_c  = own_c ? m0.req  : m1.req;
  assign own_lock_c = own_c ? m1.lock : m0.lock;
  assign own_we_c   = own_c ? m1.we   : m0.we;
  assign other_c    = own_c ? OWN0 : OWN1;
  assign issue_c    = owned_c && own_req_c;

  // State register and read-return pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      rr_last_q <= 1'b1;
      s1_vld_q  <= 1'b0;
      s1_id_q   <= 1'b0;
      rvalid_q  <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rr_last_q <= rr_last_d;
      s1_vld_q  <= s1_vld_d;
      s1_id_q   <= s1_id_d;
      rvalid_q  <= {s1_vld_q & s1_id_q, s1_vld_q & ~s1_id_q};
      if (s1_vld_q && !s1_id_q) rdata0_q <= PrRD;
      if (s1_vld_q &&  s1_id_q) rdata1_q <= PrRD;
    end
  end

  // Next-state: ownership, hold counting and read tracking.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rr_last_d = rr_last_q;
    s1_vld_d  = issue_c && !own_we_c;
    s1_id_d   = own_c;
    case (state_q)
      IDLE: begin
        if (m0.req && m1.req) state_d = rr_last_q ? OWN0 : OWN1;
        else if (m0.req)      state_d = OWN0;
        else if (m1.req)      state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_req_c) begin
          hold_d  = '0;
          state_d = oth_req_c ? other_c : IDLE;
        end else begin
          rr_last_d = own_c;
          if (hold_q == HOLD_LAST) begin
            // Saturate at the limit; rotate only when someone waits and no lock.
            if (oth_req_c && !own_lock_c) begin
              state_d = other_c;
              hold_d  = '0;
            end
          end else begin
            hold_d = HOLD_W'(hold_q + 1'b1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus mux: fields are driven only on issue cycles.
  always_comb begin
    gnt_c      = 2'b00;
    PrAddrWire = '0;
    PrWDWire   = '0;
    PrBEWire   = '0;
    WeCPUWire  = 1'b0;
    RdCPUWire  = 1'b0;
    if (issue_c) begin
      gnt_c[own_c] = 1'b1;
      PrAddrWire   = own_c ? m1.addr : m0.addr;
      PrWDWire     = own_c ? m1.wd   : m0.wd;
      PrBEWire     = own_c ? m1.be   : m0.be;
      WeCPUWire    = own_we_c;
      RdCPUWire    = ~own_we_c;
    end
  end

  assign m0.gnt    = gnt_c[0];
  assign m1.gnt    = gnt_c[1];
  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Directed bench for pr_bus_arbiter: reset, read return, rotation, lock,
// streaming reads, reset during a transfer and byte-enabled writes.
module tb_pr_bus_arbiter;
  logic        clk;
  logic        rst_n;
  logic [29:0] PrAddrWire;
  logic [31:0] PrWDWire;
  logic [3:0]  PrBEWire;
  logic        WeCPUWire;
  logic        RdCPUWire;
  logic [31:0] PrRD;

  int n_checks;
  int n_fail;

  pr_bus_arbiter_if m0_if ();
  pr_bus_arbiter_if m1_if ();

  pr_bus_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0         (m0_if.slave),
    .m1         (m1_if.slave),
    .PrAddrWire (PrAddrWire),
    .PrWDWire   (PrWDWire),
    .PrBEWire   (PrBEWire),
    .WeCPUWire  (WeCPUWire),
    .RdCPUWire  (RdCPUWire),
    .PrRD       (PrRD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; samples are taken 3 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.req = 0; m0_if.lock = 0; m0_if.addr = '0; m0_if.wd = '0; m0_if.be = '0; m0_if.we = 0;
    m1_if.req = 0; m1_if.lock = 0; m1_if.addr = '0; m1_if.wd = '0; m1_if.be = '0; m1_if.we = 0;
    PrRD = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) tick();
    #3;
    n_checks++;
    if ({m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid});
    end
    n_checks++;
    if ({m0_if.rdata, m1_if.rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", m0_if.rdata, m1_if.rdata);
    end
    n_checks++;
    if ({PrAddrWire, PrWDWire, PrBEWire, WeCPUWire, RdCPUWire} !== 68'h0) begin
      n_fail++; $display("FAIL reset_bus: addr %h wd %h be %b we %b rd %b expected all 0", PrAddrWire, PrWDWire, PrBEWire, WeCPUWire, RdCPUWire);
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_read();
    m0_if.req = 1; m0_if.we = 0; m0_if.addr = 30'h1FC; m0_if.be = 4'hF;
    #3;
    n_checks++;
    if (m0_if.gnt !== 1'b0) begin n_fail++; $display("FAIL read_req_cycle_gnt: got %b expected 0", m0_if.gnt); end
    tick();
    #3;
    n_checks++;
    if ({m0_if.gnt, RdCPUWire, WeCPUWire} !== 3'b110) begin
      n_fail++; $display("FAIL read_issue: gnt/rd/we got %b expected 110", {m0_if.gnt, RdCPUWire, WeCPUWire});
    end
    n_checks++;
    if (PrAddrWire !== 30'h1FC) begin n_fail++; $display("FAIL read_addr: got %h expected 1fc", PrAddrWire); end
    tick();
    m0_if.req = 0; PrRD = 32'h1234;
    #3;
    n_checks++;
    if ({m0_if.gnt, m0_if.rvalid, RdCPUWire} !== 3'b000) begin
      n_fail++; $display("FAIL read_t1: gnt/rvalid/rd got %b expected 000", {m0_if.gnt, m0_if.rvalid, RdCPUWire});
    end
    tick();
    PrRD = 32'h5555;
    #3;
    n_checks++;
    if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'h1234) begin
      n_fail++; $display("FAIL read_return: rvalid %b rdata %h expected 1 1234", m0_if.rvalid, m0_if.rdata);
    end
    n_checks++;
    if (m1_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL read_m1_quiet: got %b expected 0", m1_if.rvalid); end
    tick();
    #3;
    n_checks++;
    if (m0_if.rvalid !== 1'b0 || m0_if.rdata !== 32'h1234) begin
      n_fail++; $display("FAIL read_hold: rvalid %b rdata %h expected 0 1234", m0_if.rvalid, m0_if.rdata);
    end
    tick();
  endtask

  task automatic test_rotation();
    int bad;
    apply_reset();
    m0_if.req = 1; m0_if.we = 1; m1_if.req = 1; m1_if.we = 1;
    #3;
    n_checks++;
    if ({m1_if.gnt, m0_if.gnt} !== 2'b00) begin n_fail++; $display("FAIL rot_idle: got %b expected 00", {m1_if.gnt, m0_if.gnt}); end
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      logic [1:0] exp_g;
      tick();
      #3;
      exp_g = ((k / 8) % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if ({m1_if.gnt, m0_if.gnt} !== exp_g) begin
        n_fail++; bad++;
        if (bad < 5) $display("FAIL rot_cycle%0d: gnt{m1,m0} got %b expected %b", k, {m1_if.gnt, m0_if.gnt}, exp_g);
      end
    end
    tick();
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_lock();
    apply_reset();
    m0_if.req = 1; m0_if.lock = 1; m0_if.we = 1; m1_if.req = 1; m1_if.we = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      #3;
      n_checks++;
      if ({m1_if.gnt, m0_if.gnt} !== 2'b01) begin
        n_fail++; $display("FAIL lock_cycle%0d: gnt{m1,m0} got %b expected 01", k, {m1_if.gnt, m0_if.gnt});
      end
    end
    tick();
    m0_if.lock = 0;
    #3;
    n_checks++;
    if ({m1_if.gnt, m0_if.gnt} !== 2'b01) begin n_fail++; $display("FAIL lock_drop_last_m0: got %b expected 01", {m1_if.gnt, m0_if.gnt}); end
    tick();
    #3;
    n_checks++;
    if ({m1_if.gnt, m0_if.gnt} !== 2'b10) begin n_fail++; $display("FAIL lock_drop_m1: got %b expected 10", {m1_if.gnt, m0_if.gnt}); end
    tick();
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd_tab [3];
    rd_tab[0] = 32'hA; rd_tab[1] = 32'hB; rd_tab[2] = 32'hC;
    m1_if.req = 1; m1_if.we = 0; m1_if.addr = 30'h10; m1_if.be = 4'hF;
    tick();
    // Cycles T0..T5 relative to the first issue.
    for (int c = 0; c < 6; c++) begin
      if (c == 3) m1_if.req = 0;
      if (c < 3) m1_if.addr = 30'(30'h10 + c);
      PrRD = (c >= 1 && c <= 3) ? rd_tab[c-1] : 32'hFFFF_FFFF;
      #3;
      n_checks++;
      if (m1_if.gnt !== (c < 3)) begin n_fail++; $display("FAIL b2b_gnt_c%0d: got %b expected %b", c, m1_if.gnt, (c < 3)); end
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (m1_if.rvalid !== 1'b1 || m1_if.rdata !== rd_tab[c-2]) begin
          n_fail++; $display("FAIL b2b_data_c%0d: rvalid %b rdata %h expected 1 %h", c, m1_if.rvalid, m1_if.rdata, rd_tab[c-2]);
        end
      end else begin
        n_checks++;
        if (m1_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_quiet_c%0d: rvalid got %b expected 0", c, m1_if.rvalid); end
      end
      n_checks++;
      if (m0_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_m0_rvalid_c%0d: got %b expected 0", c, m0_if.rvalid); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    m0_if.req = 1; m0_if.we = 0; m0_if.addr = 30'h20;
    tick();
    #3;
    n_checks++;
    if (m0_if.gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_issue: gnt got %b expected 1", m0_if.gnt); end
    tick();
    PrRD = 32'hBEEF;
    #3;
    n_checks++;
    if (m0_if.gnt !== 1'b1 || RdCPUWire !== 1'b1) begin n_fail++; $display("FAIL rmid_second_issue: gnt %b rd %b expected 1 1", m0_if.gnt, RdCPUWire); end
    rst_n = 0;
    #1;
    n_checks++;
    if ({m0_if.gnt, m1_if.gnt, RdCPUWire, WeCPUWire, PrAddrWire} !== 34'h0) begin
      n_fail++; $display("FAIL rmid_async: gnt0 %b gnt1 %b rd %b we %b addr %h expected all 0", m0_if.gnt, m1_if.gnt, RdCPUWire, WeCPUWire, PrAddrWire);
    end
    m0_if.req = 0;
    tick();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      #3;
      n_checks++;
      if (m0_if.rvalid !== 1'b0 || m0_if.rdata !== 32'h0) begin
        n_fail++; $display("FAIL rmid_no_rvalid_c%0d: rvalid %b rdata %h expected 0 0", c, m0_if.rvalid, m0_if.rdata);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_write();
    m0_if.req = 1; m0_if.we = 1; m0_if.be = 4'b0011; m0_if.wd = 32'hDEAD; m0_if.addr = 30'h5;
    tick();
    #3;
    n_checks++;
    if ({WeCPUWire, RdCPUWire, PrBEWire} !== 6'b10_0011 || PrWDWire !== 32'hDEAD || PrAddrWire !== 30'h5) begin
      n_fail++; $display("FAIL wr_issue: we %b rd %b be %b wd %h addr %h expected 1 0 0011 dead 5", WeCPUWire, RdCPUWire, PrBEWire, PrWDWire, PrAddrWire);
    end
    tick();
    m0_if.req = 0;
    #3;
    n_checks++;
    if ({WeCPUWire, PrBEWire} !== 5'b0 || PrWDWire !== 32'h0) begin
      n_fail++; $display("FAIL wr_after: we %b be %b wd %h expected 0 0000 0", WeCPUWire, PrBEWire, PrWDWire);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      #3;
      n_checks++;
      if (m0_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid_c%0d: got %b expected 0", c, m0_if.rvalid); end
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 0;
    clear_inputs();
    test_reset();
    test_read();
    test_rotation();
    test_lock();
    test_back_to_back();
    test_reset_mid();
    test_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
